// File: rtl/block_xfer_pkg.sv
// Shared definitions for the LDM/STM block transfer sequencer.
//   state_e    : sequencer states
//   mode_e     : addressing mode, encoded directly as {pre, up}
//   WORD_BYTES : address stride per beat
//   PC_INDEX   : register index of the program counter
package block_xfer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    WBASE
  } state_e;

  typedef enum logic [1:0] {
    DA = 2'b00,
    IA = 2'b01,
    DB = 2'b10,
    IB = 2'b11
  } mode_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [3:0]  PC_INDEX   = 4'd15;

  function automatic mode_e mode_of(input logic pre, input logic up);
    return mode_e'({pre, up});
  endfunction

endpackage

// File: rtl/block_transfer_sequencer_lsb.sv
// lowest_set_bit16: combinational priority encoder.
//   list_i  : 16-bit register list
//   idx_o   : index of the lowest set bit (0 when list is empty)
//   valid_o : list_i has at least one bit set
module lowest_set_bit16 (
  input  logic [15:0] list_i,
  output logic [3:0]  idx_o,
  output logic        valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (list_i[i] && !valid_o) begin
        idx_o   = 4'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/block_transfer_sequencer.sv
// block_transfer_sequencer: drives the register file write port and third
// read port while an LDM/STM walks its register list, one register per beat.
//   clock/reset       : rising-edge clock, synchronous active-high reset
//   start, load, pre,
//   up, wback         : request and instruction mode bits (sampled in IDLE)
//   reg_list, base_reg,
//   base_val          : transfer list, Rn index and Rn value
//   mem_*             : memory beat handshake, address and load data
//   rf_rsel           : read-port select for store data
//   rf_ld/dest/ds     : register file write port
//   pc_ld/pc_value    : R15 write path
//   stall, busy, done : pipeline freeze, activity, completion pulse
module block_transfer_sequencer #(
  parameter int unsigned DW   = 32,
  parameter int unsigned NREG = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            load,
  input  logic            pre,
  input  logic            up,
  input  logic            wback,
  input  logic [NREG-1:0] reg_list,
  input  logic [3:0]      base_reg,
  input  logic [DW-1:0]   base_val,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ready,
  output logic            mem_en,
  output logic            mem_rw,
  output logic [DW-1:0]   mem_addr,
  output logic [3:0]      rf_rsel,
  output logic            rf_ld,
  output logic [3:0]      rf_dest,
  output logic [DW-1:0]   rf_ds,
  output logic            pc_ld,
  output logic [DW-1:0]   pc_value,
  output logic            stall,
  output logic            busy,
  output logic            done
);

  import block_xfer_pkg::*;

  localparam int unsigned CW = $clog2(NREG + 1);

  state_e          state_q, state_d;
  logic [NREG-1:0] list_q, list_d;
  logic [DW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wbval_q, wbval_d;
  logic [3:0]      breg_q, breg_d;
  logic            load_q, load_d;
  logic            wb_q, wb_d;
  logic            done_q, done_d;

  logic [3:0]      cur_idx;
  logic            cur_valid;
  logic [CW-1:0]   n_cnt;
  logic [DW-1:0]   span;
  logic [DW-1:0]   word;

  lowest_set_bit16 u_lsb (
    .list_i  (list_q),
    .idx_o   (cur_idx),
    .valid_o (cur_valid)
  );

  always_comb begin
    n_cnt = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      n_cnt = n_cnt + CW'(reg_list[i]);
    end
    word = DW'(WORD_BYTES);
    span = DW'(n_cnt) * word;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      list_q  <= '0;
      addr_q  <= '0;
      wbval_q <= '0;
      breg_q  <= '0;
      load_q  <= 1'b0;
      wb_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      list_q  <= list_d;
      addr_q  <= addr_d;
      wbval_q <= wbval_d;
      breg_q  <= breg_d;
      load_q  <= load_d;
      wb_q    <= wb_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    list_d  = list_q;
    addr_d  = addr_q;
    wbval_d = wbval_q;
    breg_d  = breg_q;
    load_d  = load_q;
    wb_d    = wb_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          list_d  = reg_list;
          load_d  = load;
          breg_d  = base_reg;
          // A loaded base register takes precedence over the writeback value.
          wb_d    = wback && !(load && reg_list[base_reg]);
          wbval_d = up ? (base_val + span) : (base_val - span);
          case (mode_of(pre, up))
            IA: addr_d = base_val;
            IB: addr_d = base_val + word;
            DA: addr_d = base_val - span + word;
            DB: addr_d = base_val - span;
          endcase
          if (n_cnt == '0) done_d  = 1'b1;
          else             state_d = XFER;
        end
      end
      XFER: begin
        if (mem_ready) begin
          list_d[cur_idx] = 1'b0;
          addr_d          = addr_q + word;
          if (list_d == '0) begin
            if (wb_q) begin
              state_d = WBASE;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      WBASE: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_en   = 1'b0;
    mem_rw   = 1'b0;
    mem_addr = '0;
    rf_rsel  = '0;
    rf_ld    = 1'b0;
    rf_dest  = '0;
    rf_ds    = '0;
    pc_ld    = 1'b0;
    pc_value = '0;
    busy     = (state_q != IDLE);
    stall    = busy || ((state_q == IDLE) && start);
    done     = done_q;
    case (state_q)
      XFER: begin
        if (cur_valid) begin
          mem_en   = 1'b1;
          mem_rw   = !load_q;
          mem_addr = addr_q;
          rf_rsel  = cur_idx;
          if (load_q && mem_ready) begin
            if (cur_idx == PC_INDEX) begin
              pc_ld    = 1'b1;
              pc_value = mem_rdata;
            end else begin
              rf_ld   = 1'b1;
              rf_dest = cur_idx;
              rf_ds   = mem_rdata;
            end
          end
        end
      end
      WBASE: begin
        rf_ld   = 1'b1;
        rf_dest = breg_q;
        rf_ds   = wbval_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_block_transfer_sequencer.sv
module tb_block_transfer_sequencer;

  localparam logic [31:0] RD_MASK = 32'hA5A5_0000;

  typedef struct packed {
    logic        stall;
    logic        busy;
    logic        done;
    logic        mem_en;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [3:0]  rf_rsel;
    logic        rf_ld;
    logic [3:0]  rf_dest;
    logic [31:0] rf_ds;
    logic        pc_ld;
    logic [31:0] pc_value;
  } obs_t;

  logic        clock = 1'b0;
  logic        reset, start, load, pre, up, wback, mem_ready, pc_test;
  logic [15:0] reg_list;
  logic [3:0]  base_reg;
  logic [31:0] base_val, mem_rdata;
  logic        mem_en, mem_rw, rf_ld, pc_ld, stall, busy, done;
  logic [31:0] mem_addr, rf_ds, pc_value;
  logic [3:0]  rf_rsel, rf_dest;

  int unsigned checks = 0;
  int unsigned errors = 0;
  obs_t        exp_q[$];
  obs_t        act, expv;

  always #5 clock = ~clock;

  assign mem_rdata = pc_test ? 32'h0000_0040 : (mem_addr ^ RD_MASK);

  block_transfer_sequencer #(.DW(32), .NREG(16)) dut (
    .clock(clock), .reset(reset), .start(start), .load(load), .pre(pre),
    .up(up), .wback(wback), .reg_list(reg_list), .base_reg(base_reg),
    .base_val(base_val), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .rf_rsel(rf_rsel),
    .rf_ld(rf_ld), .rf_dest(rf_dest), .rf_ds(rf_ds), .pc_ld(pc_ld),
    .pc_value(pc_value), .stall(stall), .busy(busy), .done(done)
  );

  function automatic obs_t mk(input logic st, input logic bz, input logic dn,
                              input logic en, input logic rw, input logic [31:0] addr,
                              input logic [3:0] rsel, input logic ld, input logic [3:0] dest,
                              input logic [31:0] ds, input logic pl, input logic [31:0] pv);
    obs_t o;
    o = '{st, bz, dn, en, rw, addr, rsel, ld, dest, ds, pl, pv};
    return o;
  endfunction

  function automatic logic [31:0] rd(input logic [31:0] a);
    return a ^ RD_MASK;
  endfunction

  task automatic exp_start(input logic dn);
    exp_q.push_back(mk(1, 0, dn, 0, 0, '0, '0, 0, '0, '0, 0, '0));
  endtask

  task automatic exp_done();
    exp_q.push_back(mk(0, 0, 1, 0, 0, '0, '0, 0, '0, '0, 0, '0));
  endtask

  task automatic exp_st(input logic [31:0] addr, input logic [3:0] r);
    exp_q.push_back(mk(1, 1, 0, 1, 1, addr, r, 0, '0, '0, 0, '0));
  endtask

  task automatic exp_ld(input logic [31:0] addr, input logic [3:0] r,
                        input logic rdy, input logic [31:0] data);
    if (!rdy)         exp_q.push_back(mk(1, 1, 0, 1, 0, addr, r, 0, '0, '0, 0, '0));
    else if (r == 15) exp_q.push_back(mk(1, 1, 0, 1, 0, addr, r, 0, '0, '0, 1, data));
    else              exp_q.push_back(mk(1, 1, 0, 1, 0, addr, r, 1, r, data, 0, '0));
  endtask

  task automatic exp_wb(input logic [3:0] r, input logic [31:0] v);
    exp_q.push_back(mk(1, 1, 0, 0, 0, '0, '0, 1, r, v, 0, '0));
  endtask

  task automatic set_op(input logic l, input logic p, input logic u, input logic w,
                        input logic [15:0] lst, input logic [3:0] br, input logic [31:0] bv);
    load = l; pre = p; up = u; wback = w;
    reg_list = lst; base_reg = br; base_val = bv;
    start = 1'b1;
  endtask

  task automatic issue(input logic l, input logic p, input logic u, input logic w,
                       input logic [15:0] lst, input logic [3:0] br, input logic [31:0] bv);
    @(posedge clock); #1;
    set_op(l, p, u, w, lst, br, bv);
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic check_zero(input string name);
    logic [151:0] outs;
    outs = {mem_en, mem_rw, mem_addr, rf_rsel, rf_ld, rf_dest, rf_ds,
            pc_ld, pc_value, stall, busy, done};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL %s: outputs=%h required all zero", name, outs);
    end
  endtask

  // Monitor: every cycle with visible activity is one scoreboard transaction.
  always @(negedge clock) begin
    act = mk(stall, busy, done, mem_en, mem_rw, mem_addr, rf_rsel,
             rf_ld, rf_dest, rf_ds, pc_ld, pc_value);
    if (act.stall || act.busy || act.done || act.mem_en || act.rf_ld || act.pc_ld) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_activity: got %h required no activity", act);
      end else begin
        expv = exp_q.pop_front();
        if (act !== expv) begin
          errors++;
          $display("FAIL cycle_obs @%0t: got %h required %h", $time, act, expv);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; load = 1'b0; pre = 1'b0; up = 1'b0; wback = 1'b0;
    reg_list = '0; base_reg = '0; base_val = '0; mem_ready = 1'b1; pc_test = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check_zero("reset_state");

    // LDMIA R13!, {R1-R3}
    exp_start(0);
    exp_ld(32'h1000, 1, 1, rd(32'h1000));
    exp_ld(32'h1004, 2, 1, rd(32'h1004));
    exp_ld(32'h1008, 3, 1, rd(32'h1008));
    exp_wb(13, 32'h100C);
    exp_done();
    issue(1, 0, 1, 1, 16'h000E, 13, 32'h1000);
    repeat (7) @(posedge clock);

    // STMDB {R0, R15}
    exp_start(0);
    exp_st(32'h1FF8, 0);
    exp_st(32'h1FFC, 15);
    exp_done();
    issue(0, 1, 0, 0, 16'h8001, 13, 32'h2000);
    repeat (6) @(posedge clock);

    // LDMIB {R15}
    pc_test = 1'b1;
    exp_start(0);
    exp_ld(32'h1000, 15, 1, 32'h0000_0040);
    exp_done();
    issue(1, 1, 1, 0, 16'h8000, 0, 32'h0000_0FFC);
    repeat (5) @(posedge clock);
    pc_test = 1'b0;

    // LDMDA R1!, {R4-R6}, three wait cycles on beat 2
    exp_start(0);
    exp_ld(32'h2FF8, 4, 1, rd(32'h2FF8));
    repeat (3) exp_ld(32'h2FFC, 5, 0, '0);
    exp_ld(32'h2FFC, 5, 1, rd(32'h2FFC));
    exp_ld(32'h3000, 6, 1, rd(32'h3000));
    exp_wb(1, 32'h2FF4);
    exp_done();
    issue(1, 0, 0, 1, 16'h0070, 1, 32'h3000);
    @(posedge clock); #1 mem_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(posedge clock); #1 mem_ready = 1'b1;
    repeat (6) @(posedge clock);

    // Empty list, then LDMIA R2! {R1,R2} started in the done cycle
    exp_start(0);
    exp_start(1);
    exp_ld(32'h4000, 1, 1, rd(32'h4000));
    exp_ld(32'h4004, 2, 1, rd(32'h4004));
    exp_done();
    @(posedge clock); #1 set_op(1, 0, 1, 1, 16'h0000, 5, 32'h7000);
    @(posedge clock); #1 set_op(1, 0, 1, 1, 16'h0006, 2, 32'h4000);
    @(posedge clock); #1 start = 1'b0;
    repeat (6) @(posedge clock);

    // STMDB R3!, {R0} from base 0: address and writeback wrap
    exp_start(0);
    exp_st(32'hFFFF_FFFC, 0);
    exp_wb(3, 32'hFFFF_FFFC);
    exp_done();
    issue(0, 1, 0, 1, 16'h0001, 3, 32'h0000_0000);
    repeat (6) @(posedge clock);

    // STMIA {R0-R3}, reset during beat 2
    exp_start(0);
    exp_st(32'h5000, 0);
    exp_st(32'h5004, 1);
    issue(0, 0, 1, 0, 16'h000F, 8, 32'h5000);
    @(posedge clock); #1 mem_ready = 1'b0; reset = 1'b1;
    @(posedge clock); #1 mem_ready = 1'b1; reset = 1'b0;
    check_zero("reset_abort");
    repeat (4) @(posedge clock);

    // STMIA R4!, {R0,R1} after the abort
    exp_start(0);
    exp_st(32'h6000, 0);
    exp_st(32'h6004, 1);
    exp_wb(4, 32'h6008);
    exp_done();
    issue(0, 0, 1, 1, 16'h0003, 4, 32'h6000);
    repeat (8) @(posedge clock);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_expected: %0d transactions left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
